// File: rtl/mk_rst_seq_if.sv
// mk_rst_seq_if - handshake bundle for the staggered reset sequencer.
//   lock_in : asynchronous lock/enable (1 = clock stable)
//   sw_rst  : synchronous software reset request, level-sensitive
//   rst_out : per-channel active-high resets, bit 0 released first
//   ready   : all channels released
//   busy    : release sequence in progress
//   evt_cnt : re-arm event count (zero unless the counter is compiled in)
// master = stimulus/controller side, slave = sequencer side.
interface mk_rst_seq_if #(
   parameter int N_CH = 4
);
   logic            lock_in;
   logic            sw_rst;
   logic [N_CH-1:0] rst_out;
   logic            ready;
   logic            busy;
   logic [7:0]      evt_cnt;

   modport master (output lock_in, sw_rst, input rst_out, ready, busy, evt_cnt);
   modport slave  (input lock_in, sw_rst, output rst_out, ready, busy, evt_cnt);
endinterface

// File: rtl/mk_rst_seq.sv
// mk_rst_seq - power-on / lock-loss reset sequencer.
// Holds every reset channel for 2^CNT_W cycles once the synchronised lock is
// up, then releases the N_CH channels one by one, STAGGER cycles apart.
// Lock loss or sw_rst re-arms the whole sequence.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : mk_rst_seq_if.slave (lock_in, sw_rst in; rst_out, ready, busy,
//          evt_cnt out)
// Optional: define MK_RST_EVT_CNT_EN to build the 8-bit saturating re-arm
// event counter on evt_cnt; otherwise evt_cnt is constant zero.
module mk_rst_seq #(
   parameter int CNT_W       = 16,
   parameter int N_CH        = 4,
   parameter int STAGGER     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   mk_rst_seq_if.slave  bus
);

   localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER - 1);
   localparam logic [IW-1:0] CH_LAST   = IW'(N_CH - 1);

   typedef enum logic [1:0] {HOLD, COUNT, STAG, RUN} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-2:0] sync;
   logic                   lock_s;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [SW-1:0]          stag, stag_n;
   logic [IW-1:0]          idx, idx_n;
   logic [N_CH-1:0]        chan, chan_n;
   logic                   ready_q, ready_n;
   logic                   busy_q, busy_n;
   logic                   rearm;

   // The state/output registers form the last synchroniser stage, so a
   // lock_in change is acted upon at the SYNC_STAGES-th clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync[0] <= bus.lock_in;
         for (int i = 1; i < SYNC_STAGES - 1; i++)
            sync[i] <= sync[i-1];
      end
   end

   assign lock_s = sync[SYNC_STAGES-2];

   // Re-arm beats any normal advance on the same edge.
   assign rearm = (state != HOLD) && (!lock_s || bus.sw_rst);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      stag_n  = stag;
      idx_n   = idx;
      chan_n  = chan;
      ready_n = ready_q;
      busy_n  = busy_q;
      if (rearm) begin
         state_n = HOLD;
         cnt_n   = '0;
         stag_n  = '0;
         idx_n   = '0;
         chan_n  = '1;
         ready_n = 1'b0;
         busy_n  = 1'b0;
      end else begin
         case (state)
            HOLD: begin
               if (lock_s && !bus.sw_rst) begin
                  state_n = COUNT;
                  cnt_n   = '0;
                  busy_n  = 1'b1;
               end
            end
            COUNT: begin
               if (cnt == '1) begin
                  // Hold expired: channel 0 goes now, the rest follow.
                  chan_n[0] = 1'b0;
                  stag_n    = '0;
                  if (N_CH == 1) begin
                     state_n = RUN;
                     ready_n = 1'b1;
                     busy_n  = 1'b0;
                  end else begin
                     state_n = STAG;
                     idx_n   = IW'(1);
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            STAG: begin
               if (stag == STAG_LAST) begin
                  chan_n[idx] = 1'b0;
                  stag_n      = '0;
                  if (idx == CH_LAST) begin
                     state_n = RUN;
                     ready_n = 1'b1;
                     busy_n  = 1'b0;
                  end else begin
                     idx_n = idx + 1'b1;
                  end
               end else begin
                  stag_n = stag + 1'b1;
               end
            end
            RUN: ;
            default: state_n = HOLD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= HOLD;
         cnt     <= '0;
         stag    <= '0;
         idx     <= '0;
         chan    <= '1;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         stag    <= stag_n;
         idx     <= idx_n;
         chan    <= chan_n;
         ready_q <= ready_n;
         busy_q  <= busy_n;
      end
   end

   assign bus.rst_out = chan;
   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;

`ifdef MK_RST_EVT_CNT_EN
   logic [7:0] evt;

   // Saturating count of re-arm edges; only the async reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         evt <= '0;
      else if (rearm && (evt != 8'hFF))
         evt <= evt + 1'b1;
   end

   assign bus.evt_cnt = evt;
`else
   assign bus.evt_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_mk_rst_seq.sv
// tb_mk_rst_seq - directed self-checking bench for mk_rst_seq
// (CNT_W=4, N_CH=4, STAGGER=3, SYNC_STAGES=2). Expected evt_cnt follows
// MK_RST_EVT_CNT_EN: saturating re-arm count when defined, zero otherwise.
module tb_mk_rst_seq;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [7:0] exp_evt = 8'h00;

   mk_rst_seq_if #(.N_CH(4)) bus ();

   mk_rst_seq #(
      .CNT_W(4), .N_CH(4), .STAGGER(3), .SYNC_STAGES(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic note_rearm();
`ifdef MK_RST_EVT_CNT_EN
      if (exp_evt != 8'hFF) exp_evt = exp_evt + 8'd1;
`endif
   endtask

   task automatic chk_outs(input string tag, input logic [3:0] r,
                           input logic rdy, input logic bsy);
      chk({tag, ".rst_out"}, {4'h0, bus.rst_out}, {4'h0, r});
      chk({tag, ".ready"},   {7'h0, bus.ready},   {7'h0, rdy});
      chk({tag, ".busy"},    {7'h0, bus.busy},    {7'h0, bsy});
   endtask

   // Called just after E0; returns just after E0+25.
   task automatic seq_check(input string tag);
      tick(15); chk_outs({tag, "@15"}, 4'b1111, 1'b0, 1'b1);
      tick(1);  chk_outs({tag, "@16"}, 4'b1110, 1'b0, 1'b1);
      tick(2);  chk_outs({tag, "@18"}, 4'b1110, 1'b0, 1'b1);
      tick(1);  chk_outs({tag, "@19"}, 4'b1100, 1'b0, 1'b1);
      tick(3);  chk_outs({tag, "@22"}, 4'b1000, 1'b0, 1'b1);
      tick(2);  chk_outs({tag, "@24"}, 4'b1000, 1'b0, 1'b1);
      tick(1);  chk_outs({tag, "@25"}, 4'b0000, 1'b1, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.lock_in = 1'b1;
      bus.sw_rst  = 1'b0;

      // Power-on
      tick(3);
      chk_outs("reset", 4'b1111, 1'b0, 1'b0);
      chk("reset.evt", bus.evt_cnt, 8'h00);
      rst = 1'b0;
      tick(1); chk_outs("por.sync", 4'b1111, 1'b0, 1'b0);
      tick(1); chk_outs("por.e0", 4'b1111, 1'b0, 1'b1);
      seq_check("por");
      tick(3); chk_outs("por.run", 4'b0000, 1'b1, 1'b0);

      // sw_rst pulse in RUN
      bus.sw_rst = 1'b1;
      tick(1); note_rearm();
      chk_outs("swrst.hold", 4'b1111, 1'b0, 1'b0);
      chk("swrst.evt", bus.evt_cnt, exp_evt);
      bus.sw_rst = 1'b0;
      tick(1); chk_outs("swrst.e0", 4'b1111, 1'b0, 1'b1);

      // Lock loss mid-STAG
      tick(15); tick(1); tick(3);
      chk_outs("lock.e19", 4'b1100, 1'b0, 1'b1);
      bus.lock_in = 1'b0;
      tick(1); chk_outs("lock.edge1", 4'b1100, 1'b0, 1'b1);
      tick(1); note_rearm();
      chk_outs("lock.edge2", 4'b1111, 1'b0, 1'b0);
      chk("lock.evt", bus.evt_cnt, exp_evt);
      bus.lock_in = 1'b1;
      tick(1); chk_outs("lock.sync", 4'b1111, 1'b0, 1'b0);
      tick(1); chk_outs("lock.e0", 4'b1111, 1'b0, 1'b1);
      seq_check("relock");

      // sw_rst held in HOLD with lock up
      bus.sw_rst = 1'b1;
      tick(1); note_rearm();
      chk_outs("hold.enter", 4'b1111, 1'b0, 1'b0);
      tick(5); chk_outs("hold.mid", 4'b1111, 1'b0, 1'b0);
      tick(5); chk_outs("hold.end", 4'b1111, 1'b0, 1'b0);
      chk("hold.evt", bus.evt_cnt, exp_evt);
      bus.sw_rst = 1'b0;
      tick(1); chk_outs("hold.e0", 4'b1111, 1'b0, 1'b1);

      // Async reset mid-COUNT, between edges
      tick(5);
      #3;
      rst = 1'b1;
      #1;
      exp_evt = 8'h00;
      chk_outs("arst", 4'b1111, 1'b0, 1'b0);
      chk("arst.evt", bus.evt_cnt, exp_evt);
      tick(1);
      rst = 1'b0;
      tick(1); chk_outs("arst.sync", 4'b1111, 1'b0, 1'b0);
      tick(1); chk_outs("arst.e0", 4'b1111, 1'b0, 1'b1);
      seq_check("arst");

      // Repeated sw_rst pulses (evt_cnt saturation when the counter exists)
      for (int p = 0; p < 300; p++) begin
         bus.sw_rst = 1'b1;
         tick(1); note_rearm();
         bus.sw_rst = 1'b0;
         tick(2);
         if (p == 9) chk("evt.10", bus.evt_cnt, exp_evt);
      end
      chk("evt.sat", bus.evt_cnt, exp_evt);
      chk_outs("pulses.count", 4'b1111, 1'b0, 1'b1);
      tick(25);
      chk_outs("pulses.run", 4'b0000, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
